// File: rtl/lsu_bus_ctrl_pkg.sv
// rtl/lsu_bus_ctrl_pkg.sv - shared states, funct3 codes and access helpers for the LSU
//
// Contents:
//   lsu_state_e      controller states (IDLE/REQ/DONE)
//   F3_*             funct3 access-size codes
//   lsu_access_legal size/alignment/direction legality of an access
//   lsu_byte_en      store byte enables for a size and byte offset
//   lsu_store_data   lane-replicated store data for a size
package lsu_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size comes from f3[1:0]; stores have no unsigned variants and loads
  // have no 110 (LWU is RV64-only), so both are rejected here.
  function automatic logic lsu_access_legal(input logic [2:0] f3,
                                            input logic [1:0] addr_lo,
                                            input logic       is_store);
    logic ok;
    ok = 1'b0;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr_lo[0];
      2'b10:   ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    if (is_store && f3[2]) ok = 1'b0;
    if (!is_store && (f3 == 3'b110)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating across lanes lets the RAM pick up the data purely from bus_be.
  function automatic logic [31:0] lsu_store_data(input logic [2:0]  f3,
                                                 input logic [31:0] wdata);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// rtl/lsu_load_fmt.sv - load lane select with sign/zero extension
//
// Ports:
//   word     in  32  raw word read from the bus
//   addr_lo  in  2   byte offset within the word
//   f3       in  3   funct3 (LB/LH/LW/LBU/LHU)
//   data     out 32  formatted load value
module lsu_load_fmt
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr_lo)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    // Halves are 2-byte aligned, so only addr_lo[1] picks the lane.
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    data = word;
    case (f3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'd0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'd0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// rtl/lsu_bus_ctrl.sv - load/store unit driving a word-addressed req/ack RAM bus
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   mem_rd, mem_wr          load / store request from the datapath (store wins)
//   f3, addr, wdata         access size/sign, byte address, store data
//   rdata                   formatted load data to the datapath
//   stall                   hold PC and register write while access in flight
//   misalign                one-cycle pulse for misaligned/illegal access
//   bus_err                 one-cycle pulse on bus timeout
//   bus_req, bus_we         bus request and direction
//   bus_addr, bus_be        word address and byte enables
//   bus_wdata               lane-replicated store data
//   bus_rdata, bus_ack      read word and completion strobe
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        f3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int AW    = ADDR_W + 2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0]      load_data;
  logic             req_valid;
  logic             req_legal;
  logic             unused_addr_hi;

  // Byte-address bits above the bus window do not reach the RAM.
  assign unused_addr_hi = ^addr[31:AW];

  // Gated by rst_n so the combinational IDLE outputs are also quiet in reset.
  assign req_valid = rst_n & (mem_rd | mem_wr);
  assign req_legal = lsu_access_legal(f3, addr[1:0], mem_wr);

  lsu_load_fmt u_load_fmt (
    .word    (bus_rdata),
    .addr_lo (addr_q[1:0]),
    .f3      (f3_q),
    .data    (load_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    stall     = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'b0000;
    bus_wdata = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            addr_d  = addr[AW-1:0];
            f3_d    = f3;
            wdata_d = lsu_store_data(f3, wdata);
            we_d    = mem_wr;
            cnt_d   = '0;
            stall   = 1'b1;
            state_d = S_REQ;
          end else begin
            misalign = 1'b1;
            rdata_d  = 32'd0;
          end
        end
      end

      S_REQ: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = addr_q[AW-1:2];
        bus_be    = we_q ? lsu_byte_en(f3_q, addr_q[1:0]) : 4'b0000;
        bus_wdata = we_q ? wdata_q : 32'd0;
        // An ack in the final timeout cycle still completes the access.
        if (bus_ack) begin
          if (!we_q) rdata_d = load_data;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err = 1'b1;
          rdata_d = 32'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // Datapath commits on this edge; any request still asserted is the
        // instruction just finished, so it is not restarted.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The register is cleared on a misalign edge; masking here makes the pulse
  // cycle itself read as zero too.
  assign rdata = misalign ? 32'd0 : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb/tb_lsu_bus_ctrl.sv - randomized self-checking bench for lsu_bus_ctrl
module tb_lsu_bus_ctrl;

  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_rd, mem_wr;
  logic [2:0]        f3;
  logic [31:0]       addr, wdata;
  logic [31:0]       rdata;
  logic              stall, misalign, bus_err;
  logic              bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata, bus_rdata;
  logic              bus_ack;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .f3        (f3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit st, input logic [2:0] f, input logic [31:0] a);
    int sz;
    bit f_ok;
    if (st) f_ok = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
    else    f_ok = (f != 3'd3) && (f != 3'd6) && (f != 3'd7);
    if (!f_ok) return 0;
    sz = 1 << f[1:0];
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int sh;
    sh = a[1:0] * 8;
    case (f)
      3'd0, 3'd4: begin
        v = (w >> sh) & 32'hFF;
        if (f == 3'd0 && v >= 32'h80) v = v - 32'h100;
      end
      3'd1, 3'd5: begin
        v = (w >> sh) & 32'hFFFF;
        if (f == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_be(input bit st, input logic [2:0] f, input logic [31:0] a);
    if (!st) return 32'd0;
    if (f[1:0] == 2'd0) return 32'd1 << a[1:0];
    if (f[1:0] == 2'd1) return 32'd3 << a[1:0];
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wd(input bit st, input logic [2:0] f, input logic [31:0] w);
    if (!st) return 32'd0;
    if (f[1:0] == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (f[1:0] == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  // ---------------- one access, fully checked ----------------
  // ack_at: REQ cycle (1-based) carrying bus_ack; > TIMEOUT means never.
  task automatic run_access(input bit wr, input bit rd, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rw, input int ack_at);
    bit st, ok, done;
    int k, stalls, exp_stalls;
    logic [31:0] mask;
    st   = wr;
    ok   = m_legal(st, f, a);
    mask = (32'd1 << ADDR_W) - 1;

    @(posedge clk); #1;
    mem_wr = wr; mem_rd = rd; f3 = f; addr = a; wdata = wd;
    @(negedge clk);
    if (!ok) begin
      check("misalign_pulse", 32'(misalign), 32'd1);
      check("misalign_stall", 32'(stall), 32'd0);
      check("misalign_req", 32'(bus_req), 32'd0);
      check("misalign_rdata", rdata, 32'd0);
      exp_rdata = 32'd0;
      @(posedge clk); #1;
      mem_wr = 1'b0; mem_rd = 1'b0;
      @(negedge clk);
      check("misalign_one_cycle", 32'(misalign), 32'd0);
      check("misalign_no_req", 32'(bus_req), 32'd0);
      check("misalign_rdata_after", rdata, exp_rdata);
      return;
    end

    check("idle_misalign", 32'(misalign), 32'd0);
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_req", 32'(bus_req), 32'd0);
    stalls = int'(stall);
    k = 0;
    done = 0;
    while (!done) begin
      @(posedge clk); #1;
      k++;
      // Datapath inputs wander: the bus must stay on the latched values.
      addr  = $urandom;
      wdata = $urandom;
      bus_ack   = (k == ack_at);
      bus_rdata = (k == ack_at) ? rw : $urandom;
      @(negedge clk);
      check("req_bus_req", 32'(bus_req), 32'd1);
      check("req_we", 32'(bus_we), 32'(st));
      check("req_addr", 32'(bus_addr), (a >> 2) & mask);
      check("req_be", 32'(bus_be), m_be(st, f, a));
      check("req_wdata", bus_wdata, m_wd(st, f, wd));
      stalls += int'(stall);
      if (k == ack_at) begin
        done = 1;
        check("ack_no_err", 32'(bus_err), 32'd0);
        if (!st) exp_rdata = m_fmt(f, a, rw);
      end else if (k == TIMEOUT) begin
        done = 1;
        check("timeout_err", 32'(bus_err), 32'd1);
        exp_rdata = 32'd0;
      end else begin
        check("req_no_err", 32'(bus_err), 32'd0);
      end
    end

    // DONE: stray ack and still-high request must be ignored
    @(posedge clk); #1;
    bus_ack = 1'b1;
    bus_rdata = $urandom;
    @(negedge clk);
    check("done_req", 32'(bus_req), 32'd0);
    check("done_stall", 32'(stall), 32'd0);
    check("done_err", 32'(bus_err), 32'd0);
    check("done_rdata", rdata, exp_rdata);
    exp_stalls = (ack_at <= TIMEOUT) ? ack_at + 1 : TIMEOUT + 1;
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));

    @(posedge clk); #1;
    bus_ack = 1'b0;
    mem_wr = 1'b0; mem_rd = 1'b0;
    @(negedge clk);
    check("back_idle_req", 32'(bus_req), 32'd0);
    check("back_idle_stall", 32'(stall), 32'd0);
    check("back_idle_rdata", rdata, exp_rdata);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_rd = 1'b1; mem_wr = 1'b0; f3 = 3'b010; addr = 32'd0; wdata = 32'd0;
    bus_rdata = 32'd0; bus_ack = 1'b0;
    exp_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    mem_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed cases
    run_access(0, 1, 3'b010, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 2);
    run_access(0, 1, 3'b000, 32'h0000_0013, 32'd0, 32'h80FF_0000, 1);
    run_access(0, 1, 3'b100, 32'h0000_0013, 32'd0, 32'h80FF_0000, 3);
    run_access(0, 1, 3'b001, 32'h0000_0012, 32'd0, 32'h80FF_0000, 1);
    run_access(1, 0, 3'b000, 32'h0000_0021, 32'h0000_00A5, 32'd0, 1);
    run_access(1, 0, 3'b001, 32'h0000_0022, 32'h0000_1234, 32'd0, 2);
    run_access(0, 1, 3'b010, 32'h0000_0002, 32'd0, 32'd0, 1);
    run_access(1, 0, 3'b011, 32'h0000_0000, 32'd0, 32'd0, 1);
    run_access(1, 1, 3'b010, 32'h0000_0040, 32'h1122_3344, 32'd0, 1);
    run_access(1, 0, 3'b010, 32'h0000_0044, 32'h5566_7788, 32'd0, TIMEOUT + 5);
    run_access(0, 1, 3'b101, 32'h0000_0036, 32'd0, 32'hBEEF_1234, TIMEOUT);
    run_access(0, 1, 3'b110, 32'h0000_0000, 32'd0, 32'd0, 1);

    // reset in the middle of REQ
    @(posedge clk); #1;
    mem_rd = 1'b1; f3 = 3'b010; addr = 32'h0000_0080;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreq_rst_req", 32'(bus_req), 32'd0);
    check("midreq_rst_stall", 32'(stall), 32'd0);
    check("midreq_rst_err", 32'(bus_err), 32'd0);
    mem_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rdata = 32'd0;
    @(negedge clk);
    check("after_rst_rdata", rdata, 32'd0);
    run_access(0, 1, 3'b010, 32'h0000_0080, 32'd0, 32'hCAFE_F00D, 1);

    // randomized accesses
    for (int i = 0; i < 120; i++) begin
      bit wr, rd;
      logic [31:0] a;
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_access(wr, rd, 3'($urandom), a, $urandom, $urandom,
                 $urandom_range(1, TIMEOUT + 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit directly downstream of the datapath.
- Takes the ALU result as the byte address, the rs2 value as store data, and funct3 as the access size. Drives a word-addressed RAM bus that uses a req/ack handshake.
- Returns the aligned, sign- or zero-extended load data to the datapath read_data input.
- Asserts stall so the PC and register bank hold while a bus access is in flight.

Parameters:
- ADDR_W, 14: word-address width on the bus (byte address bits [ADDR_W+1:2]).
- TIMEOUT, 16: maximum cycles in REQ without bus_ack before a bus error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rd  in  1  current instruction is a load.
- mem_wr  in  1  current instruction is a store.
- f3  in  3  funct3 of the current instruction (access size/sign).
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- rdata  out  32  formatted load data to datapath.
- stall  out  1  hold PC/register write this cycle.
- misalign  out  1  one-cycle pulse: misaligned or illegal-size access, no bus cycle.
- bus_err  out  1  one-cycle pulse: bus timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word address.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read word.
- bus_ack  in  1  one-cycle completion strobe.

Behaviour:
- States: IDLE, REQ, DONE.
- Reset (async, rst_n=0) forces:
  - state=IDLE; all outputs 0, rdata=0; timeout counter=0.
  - Reset mid-REQ drops bus_req in the same instant; there is no completion and no error.
- IDLE:
  - If (mem_rd|mem_wr) and the access is legal and aligned: latch addr/f3/wdata/direction, go REQ. stall=1 combinationally this cycle.
  - mem_wr has priority when both mem_rd and mem_wr are set; the access is treated as a store.
- Alignment and size:
  - f3[1:0]=00: byte, any address.
  - f3[1:0]=01: half, requires addr[0]=0.
  - f3[1:0]=10: word, requires addr[1:0]=00.
  - f3[1:0]=11 is illegal, as are f3=110 for loads and f3[2]=1 for stores.
  - Illegal or misaligned: misalign=1 for that cycle, stall=0, no bus activity, rdata=0, state stays IDLE.
- REQ:
  - bus_req=1 with bus_we/bus_addr/bus_be/bus_wdata stable from latched values until ack; stall=1.
  - bus_addr = latched addr[ADDR_W+1:2].
  - bus_be: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111. bus_be is 0000 for loads and reads use the whole word.
  - bus_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - On bus_ack: for loads, register formatted rdata; go DONE.
  - Counter increments each REQ cycle without ack. When count reaches TIMEOUT-1 without ack: bus_err=1 for one cycle, rdata=0, go DONE. An ack arriving in that same cycle wins and there is no error.
- Load formatting:
  - Select lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- DONE:
  - bus_req=0, stall=0, rdata held valid. The datapath commits write-back/PC on this edge.
  - Unconditionally return to IDLE next cycle; mem_rd/mem_wr still high in DONE are ignored.
  - rdata holds its value until the next load completes.
- Latency: load/store with ack at REQ cycle k gives total stall = k+1 cycles; minimum 2 cycles per access (IDLE->REQ->DONE).
- bus_ack outside REQ is ignored.

Decomposition:
- Shared package/header:
  - State encodings: IDLE=2'd0, REQ=2'd1, DONE=2'd2.
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- One natural sub-module, lsu_load_fmt: combinational lane select plus sign/zero extension (word, addr[1:0], f3 -> 32-bit). It is reusable by a future fetch/CSR path.

Test Plan:
- LW addr=0x0000_0010, bus_rdata=0xDEADBEEF, ack at 2nd REQ cycle -> bus_addr=4, stall high 3 cycles, rdata=0xDEADBEEF in DONE.
- LB addr=0x13, bus_rdata=0x80FF_0000 -> rdata=0xFFFF_FF80. LBU at the same address -> rdata=0x0000_0080. LH addr=0x12 -> rdata=0xFFFF_80FF.
- SB addr=0x21, wdata=0x0000_00A5 -> bus_we=1, bus_addr=8, bus_be=0010, bus_wdata=0xA5A5A5A5. SH addr=0x22 -> bus_be=1100.
- LW addr=0x02 -> misalign pulse 1 cycle, bus_req never asserts, stall=0. SW with f3=011 -> misalign.
- Store with no ack (TIMEOUT=16) -> bus_req high 16 cycles, bus_err pulse on the 16th, DONE, then IDLE.
- rst_n low mid-REQ -> bus_req/stall go 0 immediately; after release, a new LW completes normally.
